// File: rtl/uart_cmd_wrapper.sv
// Copter-side UART endpoint: assembles 3-byte commands from RX and serializes
// single-byte responses on TX. RX and TX run independently (full duplex).
module uart_cmd_wrapper #(
    parameter int unsigned BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        resp_sent
);
    localparam int unsigned CNT_W = $clog2(BAUD_DIV + 1);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(BAUD_DIV);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(BAUD_DIV / 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {WAIT_CMD, WAIT_HI, WAIT_LO} frm_state_t;
    typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

    // RX synchronizer plus one extra stage for falling-edge detection
    logic rx_s1, rx_s2, rx_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= RX;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    rx_state_t        rx_state, rx_state_nxt;
    logic [CNT_W-1:0] rx_cnt, rx_cnt_nxt;
    logic [2:0]       rx_bit, rx_bit_nxt;
    logic [7:0]       rx_shift, rx_shift_nxt;
    logic             rx_rdy, rx_rdy_nxt;
    logic             rx_start_c, rx_sample_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_rdy   <= 1'b0;
        end else begin
            rx_state <= rx_state_nxt;
            rx_cnt   <= rx_cnt_nxt;
            rx_bit   <= rx_bit_nxt;
            rx_shift <= rx_shift_nxt;
            rx_rdy   <= rx_rdy_nxt;
        end
    end

    // Mid-bit sampler: first sample half a bit after the start edge, then every bit
    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_nxt   = rx_cnt;
        rx_bit_nxt   = rx_bit;
        rx_shift_nxt = rx_shift;
        rx_rdy_nxt   = 1'b0;
        rx_start_c   = 1'b0;
        rx_sample_c  = (rx_cnt == CNT_ONE);
        if (rx_state != RX_IDLE) begin
            rx_cnt_nxt = rx_sample_c ? FULL_BIT : rx_cnt - CNT_ONE;
        end
        case (rx_state)
            RX_IDLE: begin
                if (rx_d && !rx_s2) begin
                    rx_start_c   = 1'b1;
                    rx_cnt_nxt   = HALF_BIT;
                    rx_state_nxt = RX_START;
                end
            end
            RX_START: begin
                if (rx_sample_c) begin
                    rx_bit_nxt   = 3'd0;
                    rx_state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_sample_c) begin
                    rx_shift_nxt = {rx_s2, rx_shift[7:1]};
                    rx_bit_nxt   = rx_bit + 3'd1;
                    if (rx_bit == 3'd7) begin
                        rx_state_nxt = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (rx_sample_c) begin
                    rx_rdy_nxt   = rx_s2;
                    rx_state_nxt = RX_IDLE;
                end
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    frm_state_t  frm_state, frm_state_nxt;
    logic [7:0]  cmd_hold, cmd_hold_nxt;
    logic [7:0]  hi_hold, hi_hold_nxt;
    logic [7:0]  cmd_nxt;
    logic [15:0] data_nxt;
    logic        cmd_rdy_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_state <= WAIT_CMD;
            cmd_hold  <= '0;
            hi_hold   <= '0;
            cmd       <= '0;
            data      <= '0;
            cmd_rdy   <= 1'b0;
        end else begin
            frm_state <= frm_state_nxt;
            cmd_hold  <= cmd_hold_nxt;
            hi_hold   <= hi_hold_nxt;
            cmd       <= cmd_nxt;
            data      <= data_nxt;
            cmd_rdy   <= cmd_rdy_nxt;
        end
    end

    // Frame assembly; outputs publish only on the third byte, and set beats clear
    always_comb begin
        frm_state_nxt = frm_state;
        cmd_hold_nxt  = cmd_hold;
        hi_hold_nxt   = hi_hold;
        cmd_nxt       = cmd;
        data_nxt      = data;
        cmd_rdy_nxt   = cmd_rdy;
        if (clr_cmd_rdy || (rx_start_c && (frm_state == WAIT_CMD))) begin
            cmd_rdy_nxt = 1'b0;
        end
        case (frm_state)
            WAIT_CMD: begin
                if (rx_rdy) begin
                    cmd_hold_nxt  = rx_shift;
                    frm_state_nxt = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (rx_rdy) begin
                    hi_hold_nxt   = rx_shift;
                    frm_state_nxt = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (rx_rdy) begin
                    cmd_nxt       = cmd_hold;
                    data_nxt      = {hi_hold, rx_shift};
                    cmd_rdy_nxt   = 1'b1;
                    frm_state_nxt = WAIT_CMD;
                end
            end
            default: frm_state_nxt = WAIT_CMD;
        endcase
    end

    tx_state_t        tx_state, tx_state_nxt;
    logic [9:0]       tx_shift, tx_shift_nxt;
    logic [CNT_W-1:0] tx_cnt, tx_cnt_nxt;
    logic [3:0]       tx_bit, tx_bit_nxt;
    logic             resp_sent_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state  <= TX_IDLE;
            tx_shift  <= '1;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            resp_sent <= 1'b0;
        end else begin
            tx_state  <= tx_state_nxt;
            tx_shift  <= tx_shift_nxt;
            tx_cnt    <= tx_cnt_nxt;
            tx_bit    <= tx_bit_nxt;
            resp_sent <= resp_sent_nxt;
        end
    end

    // Shift register idles at all ones so the line rests at mark
    assign TX = tx_shift[0];

    always_comb begin
        tx_state_nxt  = tx_state;
        tx_shift_nxt  = tx_shift;
        tx_cnt_nxt    = tx_cnt;
        tx_bit_nxt    = tx_bit;
        resp_sent_nxt = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (send_resp) begin
                    tx_shift_nxt = {1'b1, resp, 1'b0};
                    tx_cnt_nxt   = FULL_BIT;
                    tx_bit_nxt   = 4'd0;
                    tx_state_nxt = TX_BUSY;
                end
            end
            TX_BUSY: begin
                if (tx_cnt == CNT_ONE) begin
                    tx_shift_nxt = {1'b1, tx_shift[9:1]};
                    tx_cnt_nxt   = FULL_BIT;
                    if (tx_bit == 4'd9) begin
                        resp_sent_nxt = 1'b1;
                        tx_state_nxt  = TX_IDLE;
                    end else begin
                        tx_bit_nxt = tx_bit + 4'd1;
                    end
                end else begin
                    tx_cnt_nxt = tx_cnt - CNT_ONE;
                end
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

endmodule

// File: doc/uart_cmd_wrapper.md
Name: uart_cmd_wrapper

Overview:
- Copter-side endpoint of the wireless command link.
- Deserializes 19200-baud 8N1 UART frames from the ground-station CommMaster into 3-byte commands: cmd, data_hi, data_lo.
- Presents each command to cmd_cfg with a level cmd_rdy flag.
- Serializes single-byte responses from cmd_cfg (e.g. positive ack 0xA5 after calibrate cmd 0x06) back onto TX.

Parameters:
- BAUD_DIV, 2604: clk cycles per bit at 50 MHz / 19200 baud. Minimum legal value is 4.

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- RX  in  1  serial in from CommMaster TX; asynchronous
- TX  out  1  serial out to CommMaster RX
- cmd  out  8  command byte of last complete frame
- data  out  16  {data_hi, data_lo} of last complete frame
- cmd_rdy  out  1  level; a complete 3-byte command is valid
- clr_cmd_rdy  in  1  one-cycle pulse from consumer; knocks down cmd_rdy
- resp  in  8  response byte to transmit
- send_resp  in  1  one-cycle pulse; start transmitting resp
- resp_sent  out  1  one-cycle pulse when the TX stop bit completes

Behaviour:
- Reset values:
  - TX=1 (idle/mark), cmd=0, data=0, cmd_rdy=0, resp_sent=0.
  - All FSMs return to IDLE.
  - Async reset mid-frame discards any partial byte or command.
- RX path:
  - RX passes through a 2-flop synchronizer, reset to 1. A start is detected on a synchronized 1->0 transition while in RX IDLE.
  - The bit counter loads BAUD_DIV/2 at start detect, then BAUD_DIV after each sample. Start, 8 data bits (LSB first) and stop are each sampled at mid-bit.
  - If the start bit samples 1 at mid-bit, it is a glitch: return to IDLE with no byte.
  - A stop bit sampling 0 is a framing error: the byte is dropped and the frame FSM is not advanced.
  - A valid byte produces an internal one-cycle rx_rdy pulse in the cycle after the stop-bit sample.
- Frame FSM states: WAIT_CMD, WAIT_HI, WAIT_LO.
  - WAIT_CMD + rx_rdy: latch byte into the cmd holding reg -> WAIT_HI.
  - WAIT_HI + rx_rdy: latch data_hi -> WAIT_LO.
  - WAIT_LO + rx_rdy: latch data_lo; update cmd and data outputs together; set cmd_rdy -> WAIT_CMD.
  - cmd and data outputs change only on completion of a frame. Partial frames never alter them.
  - cmd_rdy rises 1 cycle after the third byte's rx_rdy.
- cmd_rdy clear rules:
  - Cleared by clr_cmd_rdy.
  - Also cleared at the start detect of the next frame's first byte, so the consumer never sees stale-ready during a new frame.
  - If clr_cmd_rdy and set coincide in the same cycle, set wins.
  - There is no inter-byte timeout; the FSM waits indefinitely for the remaining bytes.
- TX path:
  - send_resp in TX IDLE loads the shift register {1, resp, 0}; TX drives the start bit the next cycle.
  - Each bit is held BAUD_DIV cycles, LSB first, then the stop bit.
  - resp_sent pulses for 1 cycle at the end of the stop bit, 10*BAUD_DIV+1 cycles after send_resp. The FSM returns to IDLE the same cycle.
  - send_resp while TX is busy is ignored (no queueing). resp is sampled only at load.
- RX and TX are fully independent and operate full-duplex.

Test Plan:
- Reset: hold rst_n=0 for 5 cycles, RX=1 -> TX=1, cmd_rdy=0, cmd=0x00, data=0x0000. Assert rst_n mid-byte -> same values immediately (async).
- Calibrate cmd: CommMaster sends cmd 0x06, data 0x0000 -> after the third stop bit, cmd_rdy=1, cmd=0x06, data=0x0000. Pulse clr_cmd_rdy -> cmd_rdy=0 next cycle; cmd and data hold.
- Data path: send cmd 0x02, data 0x1234 -> cmd=0x02, data=0x1234 (hi byte first on the wire). Then send 0x05/0xBEEF without clearing -> cmd_rdy drops at the new start bit and rises again with cmd=0x05, data=0xBEEF.
- Response: send_resp with resp=0xA5 -> TX waveform 0,1,0,1,0,0,1,0,1,1 at BAUD_DIV spacing. resp_sent pulses at cycle 10*BAUD_DIV+1; CommMaster resp=0xA5. A second send_resp mid-transmission is ignored.
- Error cases:
  - 0.25-bit low glitch on RX -> no byte, FSM stays in WAIT_CMD.
  - Frame with stop bit forced 0 on byte 2 -> byte dropped; the next two valid bytes complete the frame as hi/lo.
- Simultaneity: clr_cmd_rdy in the same cycle cmd_rdy is set -> cmd_rdy=1. Concurrent RX of a frame and TX of a response -> both complete correctly.
